// File: rtl/br_resolve_ctrl_pkg.sv
// Shared constants and types for the EX-stage branch resolve block.
// funct3 branch codes and redirect FSM state encoding.
package br_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/br_resolve_ctrl_if.sv
// EX-side bundle for br_resolve_ctrl: decode/flags/operands in,
// redirect, flushes, pulses and statistics counters out.
interface br_resolve_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_valid;
  logic                  i_stall;
  logic                  i_branch;
  logic                  i_jal;
  logic                  i_jalr;
  logic [2:0]            i_funct3;
  logic                  i_ctrl_LT;
  logic                  i_ctrl_LTU;
  logic                  i_ctrl_EQ;
  logic [DATA_WIDTH-1:0] i_pc;
  logic [DATA_WIDTH-1:0] i_imm;
  logic [DATA_WIDTH-1:0] i_rs1;
  logic                  o_redirect;
  logic [DATA_WIDTH-1:0] o_target;
  logic                  o_flush_ifid;
  logic                  o_flush_idex;
  logic                  o_misalign;
  logic                  o_illegal;
  logic [CNT_WIDTH-1:0]  o_br_cnt;
  logic [CNT_WIDTH-1:0]  o_br_taken_cnt;

  modport master (
    output i_valid, i_stall, i_branch, i_jal, i_jalr,
    output i_funct3, i_ctrl_LT, i_ctrl_LTU, i_ctrl_EQ,
    output i_pc, i_imm, i_rs1,
    input  o_redirect, o_target, o_flush_ifid,
    input  o_flush_idex, o_misalign, o_illegal,
    input  o_br_cnt, o_br_taken_cnt
  );

  modport slave (
    input  i_valid, i_stall, i_branch, i_jal, i_jalr,
    input  i_funct3, i_ctrl_LT, i_ctrl_LTU, i_ctrl_EQ,
    input  i_pc, i_imm, i_rs1,
    output o_redirect, o_target, o_flush_ifid,
    output o_flush_idex, o_misalign, o_illegal,
    output o_br_cnt, o_br_taken_cnt
  );

endinterface

// File: rtl/br_cond_eval.sv
// Branch condition decode: funct3 + comparator flags -> cond/illegal.
// Ports: i_funct3, i_lt, i_ltu, i_eq in; o_cond, o_illegal out.
module br_cond_eval
  import br_resolve_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_lt,
  input  logic       i_ltu,
  input  logic       i_eq,
  output logic       o_cond,
  output logic       o_illegal
);

  always_comb begin
    o_cond    = 1'b0;
    o_illegal = 1'b0;
    unique case (i_funct3)
      F3_BEQ:  o_cond = i_eq;
      F3_BNE:  o_cond = ~i_eq;
      F3_BLT:  o_cond = i_lt;
      F3_BGE:  o_cond = ~i_lt;
      F3_BLTU: o_cond = i_ltu;
      F3_BGEU: o_cond = ~i_ltu;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch/jump resolve: taken decision, target, registered
// redirect+flush FSM, misalign/illegal pulses, branch statistics.
// Ports: i_clk, i_rst (async, active-high), bus (slave side of
// br_resolve_ctrl_if carrying EX inputs and redirect/counter outputs).
module br_resolve_ctrl
  import br_resolve_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  br_resolve_ctrl_if.slave  bus
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic                  misalign_q, misalign_d;
  logic                  illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_WIDTH-1:0]  tk_cnt_q, tk_cnt_d;

  logic                  cond;
  logic                  cond_ill;
  logic                  accept;
  logic                  is_br;
  logic                  taken;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] base;
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] target;

  br_cond_eval u_cond (
    .i_funct3  (bus.i_funct3),
    .i_lt      (bus.i_ctrl_LT),
    .i_ltu     (bus.i_ctrl_LTU),
    .i_eq      (bus.i_ctrl_EQ),
    .o_cond    (cond),
    .o_illegal (cond_ill)
  );

  assign accept = bus.i_valid & ~bus.i_stall
                & (state_q == ST_IDLE);

  // jal/jalr outrank a simultaneous branch decode
  assign is_br = bus.i_branch & ~bus.i_jal & ~bus.i_jalr;
  assign taken = bus.i_jal | bus.i_jalr | (is_br & cond);

  assign base   = bus.i_jalr ? bus.i_rs1 : bus.i_pc;
  assign sum    = base + bus.i_imm;
  assign target = {sum[DATA_WIDTH-1:1], sum[0] & ~bus.i_jalr};

  assign misalign = taken & target[1];

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    misalign_d = accept & misalign;
    illegal_d  = accept & is_br & cond_ill;
    br_cnt_d   = br_cnt_q;
    tk_cnt_d   = tk_cnt_q;

    if (accept & is_br) begin
      br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
    end
    if (accept & is_br & cond) begin
      tk_cnt_d = tk_cnt_q + CNT_WIDTH'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (accept & taken & ~misalign) begin
          target_d = target;
          state_d  = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (~bus.i_stall) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      br_cnt_q   <= '0;
      tk_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      misalign_q <= misalign_d;
      illegal_q  <= illegal_d;
      br_cnt_q   <= br_cnt_d;
      tk_cnt_q   <= tk_cnt_d;
    end
  end

  logic redir;
  assign redir = (state_q == ST_REDIRECT);

  assign bus.o_redirect     = redir;
  assign bus.o_flush_ifid   = redir;
  assign bus.o_flush_idex   = redir;
  assign bus.o_target       = redir ? target_q : '0;
  assign bus.o_misalign     = misalign_q;
  assign bus.o_illegal      = illegal_q;
  assign bus.o_br_cnt       = br_cnt_q;
  assign bus.o_br_taken_cnt = tk_cnt_q;

endmodule
